core_mc: RTL and testbench
==========================

# core_mc

Multi-cycle, parametrised successor to the single-cycle 9-bit core top. It executes the same 9-bit instruction format with a FETCH/EXEC/MEM sequencer, so the PC, register file, ALU and zero flag live inside one block. Instruction memory is external and reads combinationally. Data memory is external behind a req/ack handshake, so stores and loads may take wait states. A start/done handshake lets a testbench or host launch a program and detect HALT.

## Interface
- DW, 8: data/register width; also the data-address width.
- PCW, 8: PC / instruction-address width.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; one clock; reset is asynchronous and active-low.
- start  in  1  one-cycle pulse; honoured only in IDLE or HALT.
- busy  out  1  high in FETCH/EXEC/MEM.
- done  out  1  high while in HALT.
- imem_addr  out  PCW  equals PC.
- imem_data  in  9  instruction at imem_addr, combinational.
- dmem_req  out  1  memory request; held until ack.
- dmem_we  out  1  1 = store, 0 = load; valid with req.
- dmem_addr  out  DW  rb value.
- dmem_wdata  out  DW  ra value.
- dmem_rdata  in  DW  load data, valid with ack.
- dmem_ack  in  1  completes the request this cycle.

## Operation
- Encoding fields:
  - op = inst[8:6]; ra = inst[3:2]; rb = inst[1:0].
  - dir = inst[5] (1 = right).
  - imm6 = inst[5:0].
- Register file: 4 × DW. Zero flag z is 1 bit.
- Opcodes:
  - 0 ADD: ra = ra + rb.
  - 1 SUB: ra = ra − rb.
  - 2 LSH: ra shifted logically by inst[1:0]+1, direction dir.
  - 3 LDI: r1 = zero-extended imm6; if DW < 6, truncate imm6.
  - 4 LDR: ra = mem[rb].
  - 5 STR: mem[rb] = ra.
  - 6 BZ: if z, PC = PC + sign-extended imm6; else PC + 1.
  - 7 HALT.
- Arithmetic is modulo 2^DW with no carry out. z is updated only by ADD, SUB and LSH (z = result == 0).
- The PC increments and adds modulo 2^PCW; wrap-around is legal.
- BZ with offset 0 is a legal self-loop.
- States:
  - IDLE → FETCH on start; PC cleared to 0.
  - FETCH: latch imem_data into IR → EXEC.
  - EXEC:
    - ALU ops, LDI and BZ write back, update PC → FETCH.
    - LDR and STR → MEM.
    - HALT → HALT with PC not advanced.
  - MEM: dmem_req = 1 and address/data stable until dmem_ack. On ack, LDR writes dmem_rdata to ra, PC + 1 → FETCH.
  - HALT: start → FETCH with PC = 0. Registers and z are retained.
- start outside IDLE/HALT is ignored.
- dmem_ack outside MEM is ignored.

## Timing
- Reset values:
  - State IDLE; PC = 0; IR = 0; registers = 0; z = 0.
  - busy = 0; done = 0; dmem_req = 0; dmem_we = 0.
  - imem_addr = 0; dmem_addr = 0; dmem_wdata = 0.
- Latencies:
  - ALU ops, LDI and BZ: 2 cycles per instruction.
  - LDR/STR: 3 cycles plus N wait cycles, where ack arrives N cycles after req rises.
  - Ack in the first MEM cycle gives N = 0.
- done rises on the cycle after HALT is decoded in EXEC.
- Write-back is visible to the next instruction's EXEC; no forwarding is needed.
- Reset asserted mid-MEM drops dmem_req asynchronously. No write is implied, and the memory side must abandon the request.
- start in the same cycle as reset release is ignored.

## Configuration
- CORE_MC_CYCLE_CNT_EN:
  - Defined: adds output cycle_cnt[31:0]. It clears on reset and on an accepted start, increments every cycle while busy, and saturates at all-ones.
  - Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package core_mc_pkg:
  - Opcode enum: kADD, kSUB, kLSH, kLDI, kLDR, kSTR, kBZ, kHALT.
  - State enum: IDLE, FETCH, EXEC, MEM, HALT.
  - Field-position constants.
- One sub-module, core_mc_alu: combinational ADD/SUB/LSH, parametrised by DW, producing rslt and z.
- Sequencer, register file and PC live in core_mc.

## Test plan
- Program LDI 5; ADD r0, r1; HALT with DW=8 → r0 = 5; done rises on cycle 7 after start; busy falls the same cycle.
- LDI 0x3F then LSH right, amount 2 (inst[1:0]=1) → ra = 0x0F; z = 0. SUB r1, r1 → z = 1. Then BZ −2 → PC decreases by 2.
- STR with ack delayed 3 cycles → dmem_req high for exactly 4 cycles; addr/wdata constant throughout; one write.
- LDR with ack and dmem_rdata = 0xA5 on the first MEM cycle → ra = 0xA5; instruction takes 3 cycles.
- PC at 0xFF executing ADD → next imem_addr = 0x00. Reset pulled low during MEM wait → dmem_req = 0 immediately; state IDLE; registers 0.
- With CORE_MC_CYCLE_CNT_EN, run the first program → cycle_cnt = 6. Restart from HALT → counter clears to 0.

Source files
------------

// File: rtl/core_mc_pkg.sv
// Shared types and instruction-field positions for the multi-cycle 9-bit core.
// Consumed by core_mc and core_mc_alu.
package core_mc_pkg;

    typedef enum logic [2:0] {
        kADD  = 3'd0,
        kSUB  = 3'd1,
        kLSH  = 3'd2,
        kLDI  = 3'd3,
        kLDR  = 3'd4,
        kSTR  = 3'd5,
        kBZ   = 3'd6,
        kHALT = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        HALT  = 3'd4
    } state_e;

    localparam int INST_W  = 9;
    localparam int OP_MSB  = 8;
    localparam int OP_LSB  = 6;
    localparam int DIR_BIT = 5;
    localparam int RA_MSB  = 3;
    localparam int RA_LSB  = 2;
    localparam int RB_MSB  = 1;
    localparam int RB_LSB  = 0;
    localparam int IMM_MSB = 5;
    localparam int IMM_W   = 6;

endpackage

// File: rtl/core_mc_alu.sv
// Combinational ALU for the multi-cycle core: ADD, SUB and logical shift by 1..4,
// all modulo 2^DW, with a zero flag on the result.
module core_mc_alu
    import core_mc_pkg::*;
#(
    parameter int DW = 8
) (
    input  opcode_e       op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [1:0]    shamt,
    input  logic          dir,
    output logic [DW-1:0] rslt,
    output logic          z
);

    logic [2:0] amt;

    always_comb begin
        // Encoded shift amount 0..3 means a shift of 1..4 positions.
        amt  = {1'b0, shamt} + 3'd1;
        rslt = '0;
        case (op)
            kADD:    rslt = a + b;
            kSUB:    rslt = a - b;
            kLSH:    rslt = dir ? (a >> amt) : (a << amt);
            default: rslt = '0;
        endcase
        z = (rslt == '0);
    end

endmodule

// File: rtl/core_mc.sv
// Multi-cycle 9-bit core: FETCH/EXEC/MEM sequencer with PC, 4-entry register file,
// zero flag and a req/ack data-memory port. Optional cycle_cnt output: CORE_MC_CYCLE_CNT_EN.
module core_mc
    import core_mc_pkg::*;
#(
    parameter int DW  = 8,
    parameter int PCW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [PCW-1:0]    imem_addr,
    input  logic [INST_W-1:0] imem_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DW-1:0]     dmem_addr,
    output logic [DW-1:0]     dmem_wdata,
    input  logic [DW-1:0]     dmem_rdata,
    input  logic              dmem_ack,
`ifdef CORE_MC_CYCLE_CNT_EN
    output logic [31:0]       cycle_cnt,
`endif
    output logic [2:0]        dbg_state
);

    localparam int IMM_KEEP = (DW < IMM_W) ? DW : IMM_W;

    state_e              state;
    logic [INST_W-1:0]   ir;
    logic [PCW-1:0]      pc;
    logic [DW-1:0]       regs [4];
    logic                z;
    logic                armed;

    opcode_e             op;
    logic [1:0]          ra;
    logic [1:0]          rb;
    logic [DW-1:0]       alu_rslt;
    logic                alu_z;
    logic [DW-1:0]       imm_val;
    logic signed [IMM_W-1:0] imm_s;
    logic [PCW-1:0]      br_off;
    logic [PCW-1:0]      pc_inc;
    logic                start_ok;

    assign op        = opcode_e'(ir[OP_MSB:OP_LSB]);
    assign ra        = ir[RA_MSB:RA_LSB];
    assign rb        = ir[RB_MSB:RB_LSB];
    assign imm_s     = signed'(ir[IMM_MSB:0]);
    assign br_off    = PCW'(imm_s);
    assign pc_inc    = pc + PCW'(1);
    assign imem_addr = pc;
    assign dbg_state = state;

    // armed blocks a start that coincides with the first edge after reset release.
    assign start_ok  = start && armed && ((state == IDLE) || (state == HALT));

    always_comb begin
        imm_val = '0;
        imm_val[IMM_KEEP-1:0] = ir[IMM_KEEP-1:0];
    end

    core_mc_alu #(.DW(DW)) u_alu (
        .op    (op),
        .a     (regs[ra]),
        .b     (regs[rb]),
        .shamt (ir[RB_MSB:RB_LSB]),
        .dir   (ir[DIR_BIT]),
        .rslt  (alu_rslt),
        .z     (alu_z)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pc         <= '0;
            ir         <= '0;
            z          <= 1'b0;
            armed      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE, HALT: begin
                    if (start_ok) begin
                        state <= FETCH;
                        pc    <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                FETCH: begin
                    ir    <= imem_data;
                    state <= EXEC;
                end
                EXEC: begin
                    case (op)
                        kADD, kSUB, kLSH: begin
                            regs[ra] <= alu_rslt;
                            z        <= alu_z;
                            pc       <= pc_inc;
                            state    <= FETCH;
                        end
                        kLDI: begin
                            regs[1] <= imm_val;
                            pc      <= pc_inc;
                            state   <= FETCH;
                        end
                        kLDR, kSTR: begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= (op == kSTR);
                            dmem_addr  <= regs[rb];
                            dmem_wdata <= regs[ra];
                            state      <= MEM;
                        end
                        kBZ: begin
                            pc    <= z ? (pc + br_off) : pc_inc;
                            state <= FETCH;
                        end
                        kHALT: begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= HALT;
                        end
                        default: state <= FETCH;
                    endcase
                end
                MEM: begin
                    // Request and its address/data stay frozen until the memory acks.
                    if (dmem_ack) begin
                        if (!dmem_we) regs[ra] <= dmem_rdata;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        pc       <= pc_inc;
                        state    <= FETCH;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CORE_MC_CYCLE_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
        end else if (start_ok) begin
            cycle_cnt <= '0;
        end else if (busy && (cycle_cnt != '1)) begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_core_mc.sv
// Self-checking bench for core_mc: directed scenarios plus random programs checked
// against an instruction-level reference model with a req/ack memory responder.
module tb_core_mc;
  import core_mc_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        busy, done;
  logic [7:0]  imem_addr;
  logic [8:0]  imem_data;
  logic        dmem_req, dmem_we;
  logic [7:0]  dmem_addr, dmem_wdata;
  logic [7:0]  dmem_rdata;
  logic        dmem_ack;
  logic [2:0]  dbg_state;
`ifdef CORE_MC_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;
`endif

  logic [8:0]  imem [256];
  logic [7:0]  dmem [256];
  assign imem_data = imem[imem_addr];

  int n_checks = 0;
  int n_fail = 0;

  // memory responder state
  int          delay_q[$];
  logic [15:0] act_q[$];
  bit          in_req = 0;
  bit          spurious_ack = 0;
  int          cur_delay, wait_cnt, req_cycles;
  bit          req_stable;
  logic [7:0]  req_addr0, req_wdata0;

  // reference model state
  int          m_regs[4];
  bit          m_z;
  int          m_mem[256];
  int          m_delays[$];
  logic [15:0] exp_q[$];

  core_mc #(.DW(8), .PCW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
`ifdef CORE_MC_CYCLE_CNT_EN
    .cycle_cnt(cycle_cnt),
`endif
    .dbg_state(dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  // data-memory responder: acks N cycles after req rises, N taken from delay_q
  initial begin
    dmem_ack = 1'b0;
    dmem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset) begin
        dmem_ack = 1'b0;
        in_req = 0;
      end else if (dmem_ack) begin
        dmem_ack = 1'b0;
        in_req = 0;
      end else if (dmem_req) begin
        if (!in_req) begin
          in_req = 1;
          cur_delay = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
          wait_cnt = 0;
          req_cycles = 0;
          req_stable = 1;
          req_addr0 = dmem_addr;
          req_wdata0 = dmem_wdata;
        end
        req_cycles++;
        if (dmem_addr !== req_addr0 || dmem_wdata !== req_wdata0) req_stable = 0;
        if (wait_cnt == cur_delay) begin
          dmem_ack = 1'b1;
          if (dmem_we) begin
            dmem[dmem_addr] = dmem_wdata;
            act_q.push_back({dmem_addr, dmem_wdata});
          end else begin
            dmem_rdata = dmem[dmem_addr];
          end
        end
        wait_cnt++;
      end else begin
        dmem_ack = spurious_ack;
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
    m_z = 0;
    delay_q.delete();
    m_delays.delete();
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 9'h1C0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // cyc counts the start edge plus every edge until done is seen
  task automatic run_prog(output int cyc, output bit to);
    pulse_start();
    cyc = 1;
    to = 0;
    while (done !== 1'b1) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc > 3000) begin
        to = 1;
        break;
      end
    end
  endtask

  // instruction-level reference model: 2 cycles per instruction, 3+N for loads/stores
  task automatic model_run(output int cyc, output int halt_pc);
    int pc, steps, op, ra, rb, a, b, r, d, off;
    logic [8:0] ins;
    bit fin;
    pc = 0; cyc = 1; steps = 0; fin = 0; halt_pc = -1;
    while (!fin && steps < 4000) begin
      ins = imem[pc];
      op = int'(ins[8:6]); ra = int'(ins[3:2]); rb = int'(ins[1:0]);
      a = m_regs[ra]; b = m_regs[rb];
      steps++;
      case (op)
        0: begin r = (a + b) % 256; m_regs[ra] = r; m_z = (r == 0); pc = (pc + 1) % 256; cyc += 2; end
        1: begin r = (a - b + 256) % 256; m_regs[ra] = r; m_z = (r == 0); pc = (pc + 1) % 256; cyc += 2; end
        2: begin
          r = ins[5] ? (a >> (rb + 1)) : ((a << (rb + 1)) % 256);
          m_regs[ra] = r; m_z = (r == 0); pc = (pc + 1) % 256; cyc += 2;
        end
        3: begin m_regs[1] = int'(ins[5:0]); pc = (pc + 1) % 256; cyc += 2; end
        4: begin d = m_delays.pop_front(); m_regs[ra] = m_mem[b]; pc = (pc + 1) % 256; cyc += 3 + d; end
        5: begin
          d = m_delays.pop_front(); m_mem[b] = a;
          exp_q.push_back({8'(b), 8'(a)});
          pc = (pc + 1) % 256; cyc += 3 + d;
        end
        6: begin
          off = ins[5] ? int'(ins[5:0]) - 64 : int'(ins[5:0]);
          pc = m_z ? (pc + off + 256) % 256 : (pc + 1) % 256; cyc += 2;
        end
        default: begin halt_pc = pc; cyc += 2; fin = 1; end
      endcase
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    step(2);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin n_fail++; $display("FAIL reset_req_we: got %b%b want 00", dmem_req, dmem_we); end
    n_checks++; if (imem_addr !== 8'h00 || dmem_addr !== 8'h00 || dmem_wdata !== 8'h00) begin
      n_fail++; $display("FAIL reset_addr: got %h %h %h want 00 00 00", imem_addr, dmem_addr, dmem_wdata); end
    n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (dut.regs[i] !== 8'h00) begin n_fail++; $display("FAIL reset_reg%0d: got %h want 00", i, dut.regs[i]); end
    end
    n_checks++; if (dut.z !== 1'b0) begin n_fail++; $display("FAIL reset_z: got %b want 0", dut.z); end
    // start coinciding with reset release must be ignored
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n_checks++; if (busy !== 1'b0 || dbg_state !== IDLE) begin
      n_fail++; $display("FAIL start_at_release: got busy=%b state=%0d want busy=0 state=%0d", busy, dbg_state, IDLE); end
  endtask

  task automatic test_first_prog();
    int cyc, k;
    bit to;
    do_reset();
    clear_imem();
    imem[0] = 9'h0C5;  // LDI 5
    imem[1] = 9'h001;  // ADD r0, r1
    imem[2] = 9'h1C0;  // HALT
    run_prog(cyc, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL first_timeout: got timeout want done"); end
    n_checks++; if (cyc != 7) begin n_fail++; $display("FAIL first_latency: got %0d want 7", cyc); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL first_busy_at_done: got %b want 0", busy); end
    n_checks++; if (dut.regs[0] !== 8'h05) begin n_fail++; $display("FAIL first_r0: got %h want 05", dut.regs[0]); end
    n_checks++; if (imem_addr !== 8'h02) begin n_fail++; $display("FAIL first_halt_pc: got %h want 02", imem_addr); end
`ifdef CORE_MC_CYCLE_CNT_EN
    n_checks++; if (cycle_cnt !== 32'd6) begin n_fail++; $display("FAIL first_cycle_cnt: got %0d want 6", cycle_cnt); end
`endif
    // restart from HALT: counter clears, registers retained
    pulse_start();
`ifdef CORE_MC_CYCLE_CNT_EN
    n_checks++; if (cycle_cnt !== 32'd0) begin n_fail++; $display("FAIL restart_cycle_cnt: got %0d want 0", cycle_cnt); end
`endif
    n_checks++; if (busy !== 1'b1 || imem_addr !== 8'h00) begin
      n_fail++; $display("FAIL restart_state: got busy=%b pc=%h want busy=1 pc=00", busy, imem_addr); end
    k = 0;
    while (done !== 1'b1 && k < 100) begin step(1); k++; end
    n_checks++; if (dut.regs[0] !== 8'h0A) begin n_fail++; $display("FAIL restart_r0: got %h want 0a", dut.regs[0]); end
  endtask

  task automatic test_lsh_bz();
    do_reset();
    clear_imem();
    imem[0] = 9'h0FF;  // LDI 0x3F
    imem[1] = 9'h0A5;  // LSH r1 right by 2
    imem[2] = 9'h045;  // SUB r1, r1
    imem[3] = 9'h1BE;  // BZ -2
    pulse_start();
    step(4);
    n_checks++; if (dut.regs[1] !== 8'h0F) begin n_fail++; $display("FAIL lsh_result: got %h want 0f", dut.regs[1]); end
    n_checks++; if (dut.z !== 1'b0) begin n_fail++; $display("FAIL lsh_z: got %b want 0", dut.z); end
    step(2);
    n_checks++; if (dut.z !== 1'b1 || dut.regs[1] !== 8'h00) begin
      n_fail++; $display("FAIL sub_z: got z=%b r1=%h want z=1 r1=00", dut.z, dut.regs[1]); end
    step(2);
    n_checks++; if (imem_addr !== 8'h01) begin n_fail++; $display("FAIL bz_back: got %h want 01", imem_addr); end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    clear_imem();
    imem[0] = 9'h040;    // SUB r0, r0
    imem[1] = 9'h1BE;    // BZ -2 -> 0xFF
    imem[255] = 9'h000;  // ADD r0, r0
    spurious_ack = 1;
    pulse_start();
    step(3);
    // start mid-run must be ignored
    start = 1'b1;
    step(1);
    start = 1'b0;
    n_checks++; if (imem_addr !== 8'hFF || busy !== 1'b1) begin
      n_fail++; $display("FAIL wrap_branch: got pc=%h busy=%b want pc=ff busy=1", imem_addr, busy); end
    step(2);
    n_checks++; if (imem_addr !== 8'h00) begin n_fail++; $display("FAIL wrap_inc: got %h want 00", imem_addr); end
    n_checks++; if (dut.z !== 1'b1 || dmem_req !== 1'b0) begin
      n_fail++; $display("FAIL wrap_z_req: got z=%b req=%b want z=1 req=0", dut.z, dmem_req); end
    spurious_ack = 0;
  endtask

  task automatic test_str_wait();
    int cyc;
    bit to;
    do_reset();
    clear_imem();
    imem[0] = 9'h0EA;  // LDI 0x2A
    imem[1] = 9'h001;  // ADD r0, r1
    imem[2] = 9'h0D1;  // LDI 0x11
    imem[3] = 9'h144;  // STR r1, [r0]
    imem[4] = 9'h1C0;
    delay_q.push_back(3);
    run_prog(cyc, to);
    n_checks++; if (to !== 1'b0 || cyc != 15) begin n_fail++; $display("FAIL str_latency: got %0d (timeout=%0d) want 15", cyc, to); end
    n_checks++; if (req_cycles != 4) begin n_fail++; $display("FAIL str_req_cycles: got %0d want 4", req_cycles); end
    n_checks++; if (req_stable !== 1'b1) begin n_fail++; $display("FAIL str_stable: got %b want 1", req_stable); end
    n_checks++; if (act_q.size() != 1) begin n_fail++; $display("FAIL str_write_count: got %0d want 1", act_q.size()); end
    else begin
      n_checks++; if (act_q[0] !== 16'h2A11) begin n_fail++; $display("FAIL str_write: got %h want 2a11", act_q[0]); end
    end
  endtask

  task automatic test_ldr();
    int cyc;
    bit to;
    do_reset();
    clear_imem();
    imem[0] = 9'h108;  // LDR r2, [r0]
    imem[1] = 9'h1C0;
    dmem[0] = 8'hA5;
    delay_q.push_back(0);
    run_prog(cyc, to);
    n_checks++; if (to !== 1'b0 || cyc != 6) begin n_fail++; $display("FAIL ldr_latency: got %0d (timeout=%0d) want 6", cyc, to); end
    n_checks++; if (dut.regs[2] !== 8'hA5) begin n_fail++; $display("FAIL ldr_data: got %h want a5", dut.regs[2]); end
  endtask

  task automatic test_reset_mid_mem();
    int k;
    do_reset();
    clear_imem();
    imem[0] = 9'h0C7;  // LDI 7
    imem[1] = 9'h105;  // LDR r1, [r1]
    delay_q.push_back(50);
    pulse_start();
    k = 0;
    while (dmem_req !== 1'b1 && k < 20) begin step(1); k++; end
    n_checks++; if (dmem_req !== 1'b1 || dut.regs[1] !== 8'h07) begin
      n_fail++; $display("FAIL mid_mem_setup: got req=%b r1=%h want req=1 r1=07", dmem_req, dut.regs[1]); end
    step(2);
    #2 reset = 1'b0;
    #1;
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL mid_mem_req_drop: got %b want 0", dmem_req); end
    n_checks++; if (dbg_state !== IDLE || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_mem_state: got state=%0d busy=%b want %0d/0", dbg_state, busy, IDLE); end
    n_checks++; if (dut.regs[1] !== 8'h00 || dut.regs[0] !== 8'h00) begin
      n_fail++; $display("FAIL mid_mem_regs: got r0=%h r1=%h want 00 00", dut.regs[0], dut.regs[1]); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_random();
    int cyc, exp_cyc, halt_pc, len, op, d;
    bit to;
    logic [8:0] w;
    do_reset();
    for (int i = 0; i < 256; i++) dmem[i] = 8'($urandom_range(0, 255));
    for (int p = 0; p < 6; p++) begin
      clear_imem();
      len = $urandom_range(10, 24);
      for (int i = 0; i < len; i++) begin
        w = 9'($urandom_range(0, 511));
        op = $urandom_range(0, 6);
        w[8:6] = 3'(op);
        if (op == 6) w[5:0] = 6'($urandom_range(1, 3));
        imem[i] = w;
      end
      // each program runs twice back to back; the second relaunches from HALT
      for (int r = 0; r < 2; r++) begin
        delay_q.delete(); m_delays.delete(); act_q.delete(); exp_q.delete();
        for (int i = 0; i < 40; i++) begin
          d = $urandom_range(0, 4);
          delay_q.push_back(d);
          m_delays.push_back(d);
        end
        for (int i = 0; i < 256; i++) m_mem[i] = int'(dmem[i]);
        model_run(exp_cyc, halt_pc);
        run_prog(cyc, to);
        n_checks++; if (to !== 1'b0 || cyc != exp_cyc) begin
          n_fail++; $display("FAIL rand_cycles p%0d r%0d: got %0d (timeout=%0d) want %0d", p, r, cyc, to, exp_cyc); end
        n_checks++; if (imem_addr !== 8'(halt_pc)) begin
          n_fail++; $display("FAIL rand_halt_pc p%0d: got %h want %h", p, imem_addr, 8'(halt_pc)); end
        for (int i = 0; i < 4; i++) begin
          n_checks++; if (dut.regs[i] !== 8'(m_regs[i])) begin
            n_fail++; $display("FAIL rand_reg%0d p%0d: got %h want %h", i, p, dut.regs[i], 8'(m_regs[i])); end
        end
        n_checks++; if (dut.z !== m_z) begin n_fail++; $display("FAIL rand_z p%0d: got %b want %b", p, dut.z, m_z); end
        n_checks++; if (act_q.size() != exp_q.size()) begin
          n_fail++; $display("FAIL rand_write_count p%0d: got %0d want %0d", p, act_q.size(), exp_q.size()); end
        else begin
          foreach (exp_q[i]) begin
            n_checks++; if (act_q[i] !== exp_q[i]) begin
              n_fail++; $display("FAIL rand_write p%0d #%0d: got %h want %h", p, i, act_q[i], exp_q[i]); end
          end
        end
      end
    end
  endtask

  initial begin
    clear_imem();
    for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
    test_reset();
    test_first_prog();
    test_lsh_bz();
    test_pc_wrap();
    test_str_wait();
    test_ldr();
    test_reset_mid_mem();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
